// File: rtl/fetch_pc_unit.sv
// Program counter and in-order instruction fetch. Tracks issued fetches in a small
// circular queue, hands (pc, inst) pairs to decode, and flushes the wrong path on a taken branch.
module fetch_pc_unit #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    input  logic            ex_resolve_valid,
    input  logic            ex_take_branch,
    input  logic [XLEN-1:0] ex_target
);
    localparam int IW = $clog2(MAX_OUTSTANDING);
    localparam int PW = IW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            filled;
        logic            killed;
    } entry_t;

    entry_t          q_mem [MAX_OUTSTANDING];
    logic [XLEN-1:0] pc_q;
    logic [PW-1:0]   alloc_q, fill_q, head_q, head_nxt, count;
    logic            redirect, issue, rsp_has_slot, rsp_acc, head_live, deliver, drop;
    entry_t          head_e;
    logic            unused_tgt_lsb;

    // Target is word aligned; its low bits carry no information.
    assign unused_tgt_lsb = ^ex_target[1:0];

    assign redirect     = ex_resolve_valid & ex_take_branch;
    // Extra pointer bit distinguishes a full queue from an empty one.
    assign count        = alloc_q - head_q;
    assign imem_req_valid = !reset && (count < PW'(MAX_OUTSTANDING)) && !redirect;
    assign imem_req_addr  = pc_q;
    assign issue        = imem_req_valid & imem_req_ready;
    assign rsp_has_slot = fill_q != alloc_q;
    assign rsp_acc      = imem_rsp_valid & rsp_has_slot;

    assign head_e    = q_mem[head_q[IW-1:0]];
    assign head_live = count != '0;
    assign if_valid  = head_live & head_e.filled & !head_e.killed & !redirect;
    assign if_pc     = head_e.pc;
    assign if_inst   = head_e.inst;
    assign deliver   = if_valid & if_ready;
    assign drop      = head_live & head_e.filled & head_e.killed;

    // On redirect every filled entry is wrong-path, so head skips straight to fill.
    assign head_nxt = redirect ? fill_q + PW'(rsp_acc) : head_q + PW'(deliver | drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) q_mem[i] <= '0;
        end else begin
            if (redirect)   pc_q <= {ex_target[XLEN-1:2], 2'b00};
            else if (issue) pc_q <= pc_q + XLEN'(4);
            if (issue)   alloc_q <= alloc_q + PW'(1);
            if (rsp_acc) fill_q  <= fill_q + PW'(1);
            head_q <= head_nxt;
            // Unfilled entries are still in flight; their responses get dropped on arrival.
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                if (redirect && !q_mem[i].filled) q_mem[i].killed <= 1'b1;
            if (issue) begin
                q_mem[alloc_q[IW-1:0]].pc     <= pc_q;
                q_mem[alloc_q[IW-1:0]].inst   <= '0;
                q_mem[alloc_q[IW-1:0]].filled <= 1'b0;
                q_mem[alloc_q[IW-1:0]].killed <= 1'b0;
            end
            if (rsp_acc) begin
                q_mem[fill_q[IW-1:0]].inst   <= imem_rsp_data;
                q_mem[fill_q[IW-1:0]].filled <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && imem_rsp_valid)
            assert (rsp_has_slot) else $error("fetch_pc_unit: imem response with no outstanding request");
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic checked against
// an architectural model (expected fetch and delivery PC streams, inst = hash(pc)).
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic        ex_resolve_valid, ex_take_branch;
    logic [31:0] ex_target;
    logic        w_req_valid, w_if_valid;
    logic [31:0] w_req_addr, w_if_pc, w_if_inst;

    int tests = 0;
    int fails = 0;
    int rsp_pct = 100;
    int n_deliv = 0;
    logic [31:0] fq[$];
    logic [31:0] exp_fetch = 32'h0, exp_del = 32'h0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .ex_resolve_valid(ex_resolve_valid), .ex_take_branch(ex_take_branch), .ex_target(ex_target)
    );

    // Second instance only exercises PC wrap-around from the top of the address space.
    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .if_valid(w_if_valid), .if_ready(1'b0), .if_pc(w_if_pc), .if_inst(w_if_inst),
        .ex_resolve_valid(1'b0), .ex_take_branch(1'b0), .ex_target(32'h0)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rv, input logic [31:0] a,
                       input logic iv, input logic [31:0] pc);
        chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
        if (rv) chk({tag, ".addr"}, imem_req_addr, a);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, iv});
        if (iv) begin
            chk({tag, ".if_pc"}, if_pc, pc);
            chk({tag, ".if_inst"}, if_inst, inst_of(pc));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    // imem model (in-order, >=1 cycle latency) and architectural scoreboard.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            tick();
            if (fq.size() > 0 && $urandom_range(99) < rsp_pct) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(fq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            #3;
            if (reset) begin
                fq.delete();
                exp_fetch = 32'h0;
                exp_del   = 32'h0;
            end else begin
                if (ex_resolve_valid && ex_take_branch) begin
                    chk("redirect.req_low", {31'b0, imem_req_valid}, 32'd0);
                    chk("redirect.if_low", {31'b0, if_valid}, 32'd0);
                end
                if (imem_req_valid && imem_req_ready) begin
                    chk("sb.fetch_addr", imem_req_addr, exp_fetch);
                    fq.push_back(imem_req_addr);
                    exp_fetch += 32'd4;
                end
                if (if_valid && if_ready) begin
                    chk("sb.deliver_pc", if_pc, exp_del);
                    chk("sb.deliver_inst", if_inst, inst_of(exp_del));
                    exp_del += 32'd4;
                    n_deliv++;
                end
                if (ex_resolve_valid && ex_take_branch) begin
                    exp_fetch = ex_target & ~32'd3;
                    exp_del   = ex_target & ~32'd3;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
        ex_resolve_valid = 1'b0; ex_take_branch = 1'b0; ex_target = 32'h0;

        // Reset state
        tick(); settle();
        cyc("rst", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst.if_pc", if_pc, 32'h0);
        chk("rst.if_inst", if_inst, 32'h0);
        chk("rst.w_req_valid", {31'b0, w_req_valid}, 32'd0);
        chk("rst.w_if", {31'b0, w_if_valid} | w_if_pc | w_if_inst, 32'd0);

        // 1: streaming fetch, 1-cycle imem, decode always ready (+ wrap instance)
        tick(); reset = 1'b0; settle();
        cyc("t1.c0", 1'b1, 32'h0, 1'b0, 32'h0);
        chk("t5.first_addr", w_req_addr, 32'hFFFF_FFFC);
        tick(); settle();
        cyc("t1.c1", 1'b1, 32'h4, 1'b0, 32'h0);
        chk("t5.wrap_valid", {31'b0, w_req_valid}, 32'd1);
        chk("t5.wrap_addr", w_req_addr, 32'h0000_0000);
        tick(); settle(); cyc("t1.c2", 1'b0, 32'h0, 1'b1, 32'h0);
        tick(); settle(); cyc("t1.c3", 1'b1, 32'h8, 1'b1, 32'h4);
        tick(); settle(); cyc("t1.c4", 1'b1, 32'hC, 1'b0, 32'h0);
        tick(); settle(); cyc("t1.c5", 1'b0, 32'h0, 1'b1, 32'h8);

        // 2: decode back-pressure fills the queue
        tick(); reset = 1'b1; if_ready = 1'b0;
        tick(); reset = 1'b0; settle();
        cyc("t2.c0", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(); tick(); settle(); cyc("t2.c2", 1'b0, 32'h0, 1'b1, 32'h0);
        tick(); settle(); cyc("t2.c3", 1'b0, 32'h0, 1'b1, 32'h0);
        tick(); if_ready = 1'b1; settle(); cyc("t2.c4", 1'b0, 32'h0, 1'b1, 32'h0);
        tick(); settle(); cyc("t2.c5", 1'b1, 32'h8, 1'b1, 32'h4);

        // 3: taken branch with 0x8 buffered and 0xC in flight
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        repeat (5) tick();
        ex_resolve_valid = 1'b1; ex_take_branch = 1'b1; ex_target = 32'h100; settle();
        cyc("t3.redir", 1'b0, 32'h0, 1'b0, 32'h0);
        tick(); ex_resolve_valid = 1'b0; settle(); cyc("t3.c6", 1'b1, 32'h100, 1'b0, 32'h0);
        tick(); settle(); cyc("t3.c7", 1'b1, 32'h104, 1'b0, 32'h0);
        tick(); ex_resolve_valid = 1'b1; ex_take_branch = 1'b0; ex_target = 32'h40; settle();
        // 4: not-taken resolve changes nothing; misaligned target is word-aligned
        cyc("t4.not_taken", 1'b0, 32'h0, 1'b1, 32'h100);
        tick(); ex_take_branch = 1'b1; ex_target = 32'h103; settle();
        cyc("t4.redir", 1'b0, 32'h0, 1'b0, 32'h0);
        tick(); ex_resolve_valid = 1'b0; ex_take_branch = 1'b0; rsp_pct = 0; settle();
        cyc("t4.aligned", 1'b1, 32'h100, 1'b0, 32'h0);

        // Queue full, then 6: reset with entries outstanding
        tick(); if_ready = 1'b0;
        tick(); settle(); cyc("full.stall", 1'b0, 32'h0, 1'b0, 32'h0);
        rsp_pct = 100;
        tick(); tick(); settle();
        cyc("t6.pre", 1'b0, 32'h0, 1'b1, 32'h100);
        #1 reset = 1'b1; #1;
        cyc("t6.in_reset", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6.if_pc", if_pc, 32'h0);
        tick(); tick(); reset = 1'b0; if_ready = 1'b1; settle();
        cyc("t6.after", 1'b1, 32'h0, 1'b0, 32'h0);

        // Randomized traffic checked by the scoreboard
        for (int c = 0; c < 4000; c++) begin
            tick();
            rsp_pct          = int'($urandom_range(100, 30));
            imem_req_ready   = ($urandom_range(99) < 75);
            if_ready         = ($urandom_range(99) < 70);
            ex_resolve_valid = ($urandom_range(99) < 12);
            ex_take_branch   = 1'($urandom_range(1));
            ex_target        = $urandom;
            reset            = ($urandom_range(999) < 3);
        end
        tick(); reset = 1'b0; ex_resolve_valid = 1'b0;
        tick(); settle();
        chk("rand.deliveries", {31'b0, n_deliv > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
